// File: rtl/bomb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bomb_pkg
//  Description : Shared types and constants for the bomb controller: slot
//                state encoding, tile geometry and a small sizing helper.
//  Revision    : 1.0  initial release
// ============================================================================
package bomb_pkg;

    // Life cycle of one bomb slot
    typedef enum logic [1:0] {
        FREE    = 2'd0,
        FUSE    = 2'd1,
        EXPLODE = 2'd2
    } slot_state_e;

    localparam int TILE_SIZE  = 32;
    localparam int TILE_SHIFT = 5;

    // Larger of two integers, used to size the shared fuse/explosion counter
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : bomb_pkg
`default_nettype wire

// File: rtl/bomb_slot.sv
`default_nettype none
// ============================================================================
//  Module      : bomb_slot
//  Description : One bomb slot. Latches a tile on allocation, counts the fuse
//                down on frame pulses, then counts the explosion down and
//                returns to FREE. A single counter serves both phases.
//  Revision    : 1.0  initial release
// ============================================================================
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int FUSE_FRAMES    = 90,
    parameter int EXPLODE_FRAMES = 15,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_sof,
    input  logic        i_alloc,
    input  logic [10:0] i_tile_x,
    input  logic [10:0] i_tile_y,
    output logic        o_active,
    output logic        o_fusing,
    output logic        o_exploding,
    output logic        o_explode_start,
    output logic [10:0] o_tile_x,
    output logic [10:0] o_tile_y
);

    slot_state_e      r_state;
    slot_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [10:0]      r_tile_x;
    logic [10:0]      r_tile_y;
    logic [10:0]      w_tile_x_nxt;
    logic [10:0]      w_tile_y_nxt;
    logic             r_explode_start;
    logic             w_explode_start_nxt;

    // State, counter, latched tile and explode pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= FREE;
            r_count         <= '0;
            r_tile_x        <= '0;
            r_tile_y        <= '0;
            r_explode_start <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_count         <= w_count_nxt;
            r_tile_x        <= w_tile_x_nxt;
            r_tile_y        <= w_tile_y_nxt;
            r_explode_start <= w_explode_start_nxt;
        end
    end

    // Next-state logic; an allocation ignores a coincident frame pulse so the
    // new bomb always starts with the full fuse
    always_comb begin
        w_state_nxt         = r_state;
        w_count_nxt         = r_count;
        w_tile_x_nxt        = r_tile_x;
        w_tile_y_nxt        = r_tile_y;
        w_explode_start_nxt = 1'b0;
        case (r_state)
            FREE: begin
                if (i_alloc) begin
                    w_state_nxt  = FUSE;
                    w_count_nxt  = CNT_W'(FUSE_FRAMES);
                    w_tile_x_nxt = i_tile_x;
                    w_tile_y_nxt = i_tile_y;
                end
            end
            FUSE: begin
                if (i_sof) begin
                    if (r_count == CNT_W'(1)) begin
                        w_state_nxt         = EXPLODE;
                        w_count_nxt         = CNT_W'(EXPLODE_FRAMES);
                        w_explode_start_nxt = 1'b1;
                    end else if (r_count != '0) begin
                        w_count_nxt = r_count - CNT_W'(1);
                    end
                end
            end
            EXPLODE: begin
                if (i_sof) begin
                    if (r_count == CNT_W'(1)) begin
                        // Clearing the tile here keeps FREE slots reporting 0
                        w_state_nxt  = FREE;
                        w_count_nxt  = '0;
                        w_tile_x_nxt = '0;
                        w_tile_y_nxt = '0;
                    end else if (r_count != '0) begin
                        w_count_nxt = r_count - CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt  = FREE;
                w_count_nxt  = '0;
                w_tile_x_nxt = '0;
                w_tile_y_nxt = '0;
            end
        endcase
    end

    assign o_active        = (r_state != FREE);
    assign o_fusing        = (r_state == FUSE);
    assign o_exploding     = (r_state == EXPLODE);
    assign o_explode_start = r_explode_start;
    assign o_tile_x        = r_tile_x;
    assign o_tile_y        = r_tile_y;

endmodule : bomb_slot
`default_nettype wire

// File: rtl/bomb_controller.sv
`default_nettype none
// ============================================================================
//  Module      : bomb_controller
//  Description : Snaps the player centre to the tile grid, detects the drop
//                key edge, rejects drops onto a fusing tile or into a full
//                pool, and allocates the lowest free bomb slot.
//  Revision    : 1.0  initial release
// ============================================================================
module bomb_controller
    import bomb_pkg::*;
#(
    parameter int NUM_BOMBS      = 2,
    parameter int FUSE_FRAMES    = 90,
    parameter int EXPLODE_FRAMES = 15,
    parameter int GRID_X0        = 16,
    parameter int GRID_Y0        = 48,
    parameter int MAX_COL        = 18,
    parameter int MAX_ROW        = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     startOfFrame,
    input  logic                     drop_bomb,
    input  logic signed [10:0]       playerTopLeftX,
    input  logic signed [10:0]       playerTopLeftY,
    output logic [NUM_BOMBS-1:0]     bomb_active,
    output logic [NUM_BOMBS-1:0]     bomb_exploding,
    output logic [NUM_BOMBS-1:0]     explode_start,
    output logic [NUM_BOMBS*11-1:0]  bombTopLeftX,
    output logic [NUM_BOMBS*11-1:0]  bombTopLeftY,
    output logic                     drop_rejected
);

    localparam int CNT_W = $clog2(max_int(FUSE_FRAMES, EXPLODE_FRAMES) + 1);

    logic                 r_drop_d;
    logic                 r_drop_rejected;
    logic                 w_drop_req;
    logic signed [11:0]   w_px_ext;
    logic signed [11:0]   w_py_ext;
    logic signed [11:0]   w_cx;
    logic signed [11:0]   w_cy;
    logic signed [11:0]   w_col_raw;
    logic signed [11:0]   w_row_raw;
    logic [10:0]          w_col;
    logic [10:0]          w_row;
    logic [10:0]          w_tile_x;
    logic [10:0]          w_tile_y;
    logic                 w_dup;
    logic                 w_any_free;
    logic                 w_reject;
    logic [NUM_BOMBS-1:0] w_free_sel;
    logic [NUM_BOMBS-1:0] w_alloc;
    logic [NUM_BOMBS-1:0] w_active;
    logic [NUM_BOMBS-1:0] w_fusing;
    logic [NUM_BOMBS-1:0] w_exploding;
    logic [NUM_BOMBS-1:0] w_explode_start;
    logic [10:0]          w_slot_x [NUM_BOMBS];
    logic [10:0]          w_slot_y [NUM_BOMBS];

    // Key history for edge detection and the registered rejection pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_d        <= 1'b0;
            r_drop_rejected <= 1'b0;
        end else begin
            r_drop_d        <= drop_bomb;
            r_drop_rejected <= w_reject;
        end
    end

    assign w_drop_req = drop_bomb & ~r_drop_d;

    // Player centre relative to the playfield origin, in 12-bit signed
    assign w_px_ext  = {playerTopLeftX[10], playerTopLeftX};
    assign w_py_ext  = {playerTopLeftY[10], playerTopLeftY};
    assign w_cx      = w_px_ext + 12'sd16 - $signed(12'(GRID_X0));
    assign w_cy      = w_py_ext + 12'sd16 - $signed(12'(GRID_Y0));
    assign w_col_raw = w_cx >>> TILE_SHIFT;
    assign w_row_raw = w_cy >>> TILE_SHIFT;

    // Clamp column and row into the playfield
    always_comb begin
        w_col = w_col_raw[10:0];
        w_row = w_row_raw[10:0];
        if (w_col_raw[11]) begin
            w_col = '0;
        end else if (w_col_raw[10:0] > 11'(MAX_COL)) begin
            w_col = 11'(MAX_COL);
        end
        if (w_row_raw[11]) begin
            w_row = '0;
        end else if (w_row_raw[10:0] > 11'(MAX_ROW)) begin
            w_row = 11'(MAX_ROW);
        end
    end

    assign w_tile_x = 11'(GRID_X0) + (w_col << TILE_SHIFT);
    assign w_tile_y = 11'(GRID_Y0) + (w_row << TILE_SHIFT);

    // Duplicate check against fusing slots; exploding tiles may be reused
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (w_fusing[i] && (w_slot_x[i] == w_tile_x) && (w_slot_y[i] == w_tile_y)) begin
                w_dup = 1'b1;
            end
        end
    end

    // Lowest-index free slot, judged on slot states at the start of the cycle
    always_comb begin
        w_free_sel = '0;
        w_any_free = 1'b0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (!w_active[i] && !w_any_free) begin
                w_free_sel[i] = 1'b1;
                w_any_free    = 1'b1;
            end
        end
    end

    assign w_reject = w_drop_req & (w_dup | ~w_any_free);
    assign w_alloc  = w_free_sel & {NUM_BOMBS{w_drop_req & ~w_dup}};

    generate
        for (genvar gi = 0; gi < NUM_BOMBS; gi++) begin : g_slot
            bomb_slot #(
                .FUSE_FRAMES    (FUSE_FRAMES),
                .EXPLODE_FRAMES (EXPLODE_FRAMES),
                .CNT_W          (CNT_W)
            ) u_slot (
                .clk             (clk),
                .reset           (reset),
                .i_sof           (startOfFrame),
                .i_alloc         (w_alloc[gi]),
                .i_tile_x        (w_tile_x),
                .i_tile_y        (w_tile_y),
                .o_active        (w_active[gi]),
                .o_fusing        (w_fusing[gi]),
                .o_exploding     (w_exploding[gi]),
                .o_explode_start (w_explode_start[gi]),
                .o_tile_x        (w_slot_x[gi]),
                .o_tile_y        (w_slot_y[gi])
            );
            assign bombTopLeftX[11*gi +: 11] = w_slot_x[gi];
            assign bombTopLeftY[11*gi +: 11] = w_slot_y[gi];
        end
    endgenerate

    assign bomb_active    = w_active;
    assign bomb_exploding = w_exploding;
    assign explode_start  = w_explode_start;
    assign drop_rejected  = r_drop_rejected;

endmodule : bomb_controller
`default_nettype wire

// File: tb/tb_bomb_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bomb_controller
//  Description : Directed self-checking bench for bomb_controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bomb_controller;

    logic               clk;
    logic               reset;
    logic               startOfFrame;
    logic               drop_bomb;
    logic signed [10:0] playerTopLeftX;
    logic signed [10:0] playerTopLeftY;
    logic [1:0]         bomb_active;
    logic [1:0]         bomb_exploding;
    logic [1:0]         explode_start;
    logic [21:0]        bombTopLeftX;
    logic [21:0]        bombTopLeftY;
    logic               drop_rejected;

    int checks   = 0;
    int failures = 0;

    bomb_controller dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .drop_bomb      (drop_bomb),
        .playerTopLeftX (playerTopLeftX),
        .playerTopLeftY (playerTopLeftY),
        .bomb_active    (bomb_active),
        .bomb_exploding (bomb_exploding),
        .explode_start  (explode_start),
        .bombTopLeftX   (bombTopLeftX),
        .bombTopLeftY   (bombTopLeftY),
        .drop_rejected  (drop_rejected)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; startOfFrame = 1'b0; drop_bomb = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    // One frame pulse followed by an idle cycle; returns what the pulse edge showed
    task automatic frame(output logic [1:0] es, output logic [1:0] ex);
        startOfFrame = 1'b1; tick();
        es = explode_start; ex = bomb_exploding;
        startOfFrame = 1'b0; tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bomb_active, bomb_exploding, explode_start, drop_rejected} !== 7'd0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 0", {bomb_active, bomb_exploding, explode_start, drop_rejected});
        end
        checks++;
        if ({bombTopLeftX, bombTopLeftY} !== 44'd0) begin
            failures++;
            $display("FAIL reset_pos: got %h want 0", {bombTopLeftX, bombTopLeftY});
        end
    endtask

    task automatic test_place_hold();
        logic any_rej = 1'b0;
        playerTopLeftX = 11'sd280; playerTopLeftY = 11'sd185;
        drop_bomb = 1'b1; tick();
        checks++;
        if (bomb_active !== 2'b01) begin
            failures++; $display("FAIL place_active: got %b want 01", bomb_active);
        end
        checks++;
        if (bombTopLeftX[10:0] !== 11'd272 || bombTopLeftY[10:0] !== 11'd176) begin
            failures++;
            $display("FAIL place_tile: got (%0d,%0d) want (272,176)", bombTopLeftX[10:0], bombTopLeftY[10:0]);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (drop_rejected) any_rej = 1'b1;
        end
        checks++;
        if (bomb_active !== 2'b01 || any_rej !== 1'b0) begin
            failures++; $display("FAIL hold_key: got active=%b rej=%b want 01/0", bomb_active, any_rej);
        end
        drop_bomb = 1'b0; tick();
    endtask

    task automatic test_fuse();
        logic [1:0] es, ex;
        logic early = 1'b0;
        for (int i = 0; i < 89; i++) begin
            frame(es, ex);
            if (es != 2'b00 || ex != 2'b00) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            failures++; $display("FAIL fuse_early: got early=%b want 0", early);
        end
        frame(es, ex);
        checks++;
        if (es !== 2'b01 || ex !== 2'b01) begin
            failures++; $display("FAIL fuse_90th: got es=%b ex=%b want 01/01", es, ex);
        end
        checks++;
        if (explode_start !== 2'b00) begin
            failures++; $display("FAIL explode_pulse_width: got %b want 00", explode_start);
        end
        for (int i = 0; i < 14; i++) frame(es, ex);
        checks++;
        if (bomb_exploding !== 2'b01 || bomb_active !== 2'b01) begin
            failures++; $display("FAIL explode_14: got ex=%b act=%b want 01/01", bomb_exploding, bomb_active);
        end
        frame(es, ex);
        checks++;
        if (bomb_active !== 2'b00 || bomb_exploding !== 2'b00 || bombTopLeftX !== 22'd0 || bombTopLeftY !== 22'd0) begin
            failures++;
            $display("FAIL explode_end: got act=%b ex=%b x=%h y=%h want all 0", bomb_active, bomb_exploding, bombTopLeftX, bombTopLeftY);
        end
    endtask

    task automatic test_pool();
        playerTopLeftX = 11'sd280; playerTopLeftY = 11'sd185;
        drop_bomb = 1'b1; tick(); drop_bomb = 1'b0; tick();
        drop_bomb = 1'b1; tick();
        checks++;
        if (drop_rejected !== 1'b1 || bomb_active !== 2'b01) begin
            failures++; $display("FAIL dup_tile: got rej=%b act=%b want 1/01", drop_rejected, bomb_active);
        end
        drop_bomb = 1'b0; tick();
        checks++;
        if (drop_rejected !== 1'b0) begin
            failures++; $display("FAIL rej_pulse_width: got %b want 0", drop_rejected);
        end
        playerTopLeftX = 11'sd344;
        drop_bomb = 1'b1; tick();
        checks++;
        if (bomb_active !== 2'b11 || bombTopLeftX[21:11] !== 11'd336 || bombTopLeftY[21:11] !== 11'd176 || drop_rejected !== 1'b0) begin
            failures++;
            $display("FAIL slot1_place: got act=%b (%0d,%0d) rej=%b want 11 (336,176) 0", bomb_active, bombTopLeftX[21:11], bombTopLeftY[21:11], drop_rejected);
        end
        drop_bomb = 1'b0; tick();
        playerTopLeftX = 11'sd100; playerTopLeftY = 11'sd100;
        drop_bomb = 1'b1; tick();
        checks++;
        if (drop_rejected !== 1'b1 || bomb_active !== 2'b11) begin
            failures++; $display("FAIL pool_full: got rej=%b act=%b want 1/11", drop_rejected, bomb_active);
        end
        drop_bomb = 1'b0; tick();
    endtask

    task automatic test_clamp();
        do_reset();
        playerTopLeftX = -11'sd20; playerTopLeftY = 11'sd600;
        drop_bomb = 1'b1; tick();
        checks++;
        if (bombTopLeftX[10:0] !== 11'd16 || bombTopLeftY[10:0] !== 11'd432) begin
            failures++;
            $display("FAIL clamp_low_x_high_y: got (%0d,%0d) want (16,432)", bombTopLeftX[10:0], bombTopLeftY[10:0]);
        end
        drop_bomb = 1'b0; tick();
        playerTopLeftX = 11'sd700; playerTopLeftY = 11'sd40;
        drop_bomb = 1'b1; tick();
        checks++;
        if (bombTopLeftX[21:11] !== 11'd592 || bombTopLeftY[21:11] !== 11'd48) begin
            failures++;
            $display("FAIL clamp_high_x_low_y: got (%0d,%0d) want (592,48)", bombTopLeftX[21:11], bombTopLeftY[21:11]);
        end
        drop_bomb = 1'b0; tick();
    endtask

    task automatic test_simultaneous();
        logic [1:0] es, ex;
        logic early = 1'b0;
        do_reset();
        playerTopLeftX = 11'sd280; playerTopLeftY = 11'sd185;
        drop_bomb = 1'b1; startOfFrame = 1'b1; tick();
        drop_bomb = 1'b0; startOfFrame = 1'b0;
        checks++;
        if (bomb_active !== 2'b01) begin
            failures++; $display("FAIL drop_with_sof: got %b want 01", bomb_active);
        end
        tick();
        for (int i = 0; i < 89; i++) begin
            frame(es, ex);
            if (es != 2'b00) early = 1'b1;
        end
        frame(es, ex);
        checks++;
        if (early !== 1'b0 || es !== 2'b01) begin
            failures++; $display("FAIL sof_drop_fuse: got early=%b es=%b want 0/01", early, es);
        end
        playerTopLeftX = 11'sd344;
        drop_bomb = 1'b1; tick(); drop_bomb = 1'b0; tick();
        for (int i = 0; i < 14; i++) frame(es, ex);
        // Slot0 frees in the same cycle as the drop edge
        playerTopLeftX = 11'sd100; playerTopLeftY = 11'sd100;
        startOfFrame = 1'b1; drop_bomb = 1'b1; tick();
        startOfFrame = 1'b0;
        checks++;
        if (drop_rejected !== 1'b1 || bomb_active !== 2'b10) begin
            failures++; $display("FAIL free_and_drop: got rej=%b act=%b want 1/10", drop_rejected, bomb_active);
        end
        drop_bomb = 1'b0; tick();
        drop_bomb = 1'b1; tick();
        checks++;
        if (bomb_active !== 2'b11 || bombTopLeftX[10:0] !== 11'd112 || bombTopLeftY[10:0] !== 11'd112 || drop_rejected !== 1'b0) begin
            failures++;
            $display("FAIL retry_slot0: got act=%b (%0d,%0d) rej=%b want 11 (112,112) 0", bomb_active, bombTopLeftX[10:0], bombTopLeftY[10:0], drop_rejected);
        end
        drop_bomb = 1'b0; tick();
    endtask

    task automatic test_reset_mid_explosion();
        logic [1:0] es, ex;
        logic late = 1'b0;
        do_reset();
        playerTopLeftX = 11'sd280; playerTopLeftY = 11'sd185;
        drop_bomb = 1'b1; tick(); drop_bomb = 1'b0; tick();
        for (int i = 0; i < 95; i++) frame(es, ex);
        checks++;
        if (bomb_exploding !== 2'b01) begin
            failures++; $display("FAIL pre_reset_explode: got %b want 01", bomb_exploding);
        end
        reset = 1'b1; tick();
        checks++;
        if ({bomb_active, bomb_exploding, explode_start, drop_rejected} !== 7'd0 || {bombTopLeftX, bombTopLeftY} !== 44'd0) begin
            failures++;
            $display("FAIL reset_mid: got flags=%b pos=%h want 0", {bomb_active, bomb_exploding, explode_start, drop_rejected}, {bombTopLeftX, bombTopLeftY});
        end
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            frame(es, ex);
            if (es != 2'b00 || ex != 2'b00 || bomb_active != 2'b00) late = 1'b1;
        end
        checks++;
        if (late !== 1'b0) begin
            failures++; $display("FAIL post_reset_quiet: got activity=%b want 0", late);
        end
    endtask

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; drop_bomb = 1'b0;
        playerTopLeftX = '0; playerTopLeftY = '0;
        test_reset();
        test_place_hold();
        test_fuse();
        test_pool();
        test_clamp();
        test_simultaneous();
        test_reset_mid_explosion();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bomb_controller
`default_nettype wire
